// File: rtl/shift_add_scheduler.sv
// shift_add_scheduler: round-robin arbiter and sequencer for one shared
// N-bit shift-add multiplier datapath. It owns the bit counter, so the
// datapath only has to supply its current multiplier LSB (m).
module shift_add_scheduler #(
  parameter  int N  = 4,
  localparam int CW = $clog2(N)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       m,
  output logic [1:0] grant,
  output logic       load,
  output logic       ad,
  output logic       sh,
  output logic [1:0] done,
  output logic       idle
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHK,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      grant_q, grant_d;
  logic            last_q, last_d;   // index of the most recent winner
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            winner;
  logic            last_step;

  // The current step is the final one once N-1 shifts have already happened.
  assign last_step = (cnt_q == CW'(N - 1));
  assign grant     = grant_q;

  // State, owner, round-robin pointer and bit counter registers.
  // last resets to 1 so that requester 0 wins the first contested grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      grant_q <= 2'b00;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge value of every other, independent of statement order.
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic and output decode from the registered state (m in CHK only).
  always_comb begin
    // NOTE: every signal written below gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    winner  = 1'b0;
    load    = 1'b0;
    ad      = 1'b0;
    sh      = 1'b0;
    done    = 2'b00;
    idle    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        idle  = 1'b1;
        cnt_d = '0;
        if (req != 2'b00) begin
          // Sole requester wins; on contention the one that did not win last.
          winner  = (req == 2'b11) ? ~last_q : req[1];
          grant_d = winner ? 2'b10 : 2'b01;
          last_d  = winner;
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        load    = 1'b1;
        state_d = S_CHK;
      end

      S_CHK: begin
        if (m) begin
          ad      = 1'b1;
          state_d = S_SHIFT;
        end else begin
          sh = 1'b1;
          if (last_step) state_d = S_DONE;
          else           cnt_d   = cnt_q + CW'(1);
        end
      end

      S_SHIFT: begin
        sh = 1'b1;
        if (last_step) state_d = S_DONE;
        else begin
          cnt_d   = cnt_q + CW'(1);
          state_d = S_CHK;
        end
      end

      S_DONE: begin
        // Grant is still held this cycle, so Done lands only on the owner.
        done    = grant_q;
        grant_d = 2'b00;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

endmodule

// File: tb/tb_shift_add_scheduler.sv
// Testbench for shift_add_scheduler: a small behavioural datapath supplies m,
// a vector table covers single operations, and hand-written sequences cover
// fairness, mid-operation request changes and reset during a multiply.
module tb_shift_add_scheduler;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req;
  logic       m;
  logic [1:0] grant;
  logic       load;
  logic       ad;
  logic       sh;
  logic [1:0] done;
  logic       idle;

  logic [3:0] opnd0 = '0;
  logic [3:0] opnd1 = '0;
  logic [3:0] mreg  = '0;

  int passed = 0;
  int total  = 0;

  shift_add_scheduler #(.N(N)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .m    (m),
    .grant(grant),
    .load (load),
    .ad   (ad),
    .sh   (sh),
    .done (done),
    .idle (idle)
  );

  always #5 clk = ~clk;

  // Behavioural datapath: loads the granted operand, shifts right on sh.
  always @(posedge clk) begin
    if (load)    mreg <= grant[1] ? opnd1 : opnd0;
    else if (sh) mreg <= mreg >> 1;
  end
  assign m = mreg[0];

  task automatic check(input string name, input int actual, input int expected);
    total++;
    if (actual == expected) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, actual, expected);
  endtask

  // Every-cycle invariants: one-hot-or-zero controls, Done only on the owner.
  always @(negedge clk) begin
    if (!rst) begin
      check("onehot0_ctrl", int'($countones({load, ad, sh, |done}) <= 1), 1);
      check("done_on_grant", int'(done & ~grant), 0);
    end
  end

  typedef struct {
    logic [1:0] req;
    logic [3:0] a0;
    logic [3:0] a1;
    logic [1:0] exp_grant;
    int         exp_lat;
    int         exp_ad;
  } vec_t;

  vec_t vecs[6];

  // One full operation from an IDLE cycle; req dropped on the Done cycle.
  task automatic run_op(input vec_t v, input int idx);
    int         loadk;
    int         lat;
    int         nad;
    int         nsh;
    logic [1:0] g0;
    logic [1:0] dval;
    int         stable;
    loadk = -1; lat = -1; nad = 0; nsh = 0; g0 = '0; dval = '0; stable = 1;
    opnd0 = v.a0;
    opnd1 = v.a1;
    req   = v.req;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (load) begin
        loadk = k;
        g0    = grant;
      end
      if (loadk > 0 && grant != g0) stable = 0;
      nad += int'(ad);
      nsh += int'(sh);
      if (done != 2'b00) begin
        lat  = k;
        dval = done;
        req  = 2'b00;
        break;
      end
    end
    $display("vector %0d", idx);
    check("load_cycle", loadk, 1);
    check("grant", g0, v.exp_grant);
    check("done_latency", lat, v.exp_lat);
    check("done_value", dval, v.exp_grant);
    check("ad_count", nad, v.exp_ad);
    check("sh_count", nsh, N);
    check("grant_stable", stable, 1);
    @(negedge clk);
    check("idle_after_done", idle, 1);
    check("grant_clear", grant, 0);
  endtask

  task automatic wait_load(output int w);
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!load && w < 60);
  endtask

  task automatic wait_done(output int w);
    w = 0;
    while (done == 2'b00 && w < 60) begin
      @(negedge clk);
      w++;
    end
  endtask

  initial begin
    int         w;
    logic [1:0] gl;

    vecs[0] = '{2'b01, 4'b1011, 4'b0000, 2'b01,  9, 3};
    vecs[1] = '{2'b10, 4'b0000, 4'b0000, 2'b10,  6, 0};
    vecs[2] = '{2'b01, 4'b1111, 4'b0000, 2'b01, 10, 4};
    vecs[3] = '{2'b11, 4'b1111, 4'b0101, 2'b10,  8, 2};
    vecs[4] = '{2'b11, 4'b1000, 4'b1111, 2'b01,  7, 1};
    vecs[5] = '{2'b10, 4'b1111, 4'b1001, 2'b10,  8, 2};

    // Reset state.
    rst = 1'b1;
    req = 2'b00;
    repeat (2) @(negedge clk);
    check("rst_idle", idle, 1);
    check("rst_grant", grant, 0);
    check("rst_ctrl", int'({load, ad, sh}), 0);
    check("rst_done", done, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_no_req", idle, 1);

    // Table-driven single operations.
    for (int i = 0; i < 6; i++) run_op(vecs[i], i);

    // Req=11 held: grants alternate, one IDLE cycle between Done and Load.
    opnd0 = 4'b0110;
    opnd1 = 4'b0001;
    req   = 2'b11;
    for (int op = 0; op < 4; op++) begin
      wait_load(w);
      check("rr_load_gap", w, 1);
      gl = grant;
      check("rr_grant", gl, (op % 2) ? 2 : 1);
      wait_done(w);
      check("rr_done", done, gl);
      if (op == 3) req = 2'b00;
      @(negedge clk);
      check("rr_idle_gap", int'({idle, load}), 2);
    end

    // Req[1] raised and Req[0] dropped during Req[0]'s operation.
    opnd0 = 4'b1011;
    opnd1 = 4'b0011;
    req   = 2'b01;
    wait_load(w);
    check("mid_grant0", grant, 1);
    repeat (3) @(negedge clk);
    req = 2'b10;
    wait_done(w);
    check("mid_done0", done, 1);
    @(negedge clk);
    check("mid_idle", idle, 1);
    @(negedge clk);
    check("mid_load1", load, 1);
    check("mid_grant1", grant, 2);
    wait_done(w);
    check("mid_done1", done, 2);
    req = 2'b00;
    @(negedge clk);

    // Reset asserted mid-CHK takes effect immediately.
    opnd0 = 4'b0000;
    req   = 2'b01;
    repeat (3) @(negedge clk);
    check("pre_rst_sh", sh, 1);
    rst = 1'b1;
    #1;
    check("async_idle", idle, 1);
    check("async_grant", grant, 0);
    check("async_ctrl", int'({load, ad, sh, |done}), 0);
    @(negedge clk);
    check("rst_hold_ctrl", int'({load, ad, sh, |done}), 0);
    req = 2'b11;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_load", load, 1);
    check("post_rst_grant", grant, 1);
    wait_done(w);
    check("post_rst_done", done, 1);
    req = 2'b00;
    @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
